// File: rtl/pip_point_loader.sv
// rtl/pip_point_loader.sv - load-handshake producer writing a point stream into sequential memory addresses
// Optional running checksum enabled by defining PIP_LOADER_CHECKSUM_EN.
module pip_point_loader #(
  parameter int NUM_POINTS = 16,
  parameter int COORD_W    = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [2*COORD_W-1:0] mem_wdata,
  output logic                 load_done,
  output logic [ADDR_W:0]      count,
  output logic                 aborted,
  output logic [COORD_W-1:0]   checksum
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam int LAST_IDX = NUM_POINTS - 1;

  state_t state, state_nxt;
  logic   handshake;
  logic   start;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: if (load) state_nxt = FILL;
      FILL: begin
        in_ready  = load;
        handshake = in_valid & load;
        // Dropping load abandons the fill even if a point is on offer.
        if (!load)
          state_nxt = IDLE;
        else if (handshake && (count == LAST_IDX[ADDR_W:0]))
          state_nxt = DONE;
      end
      DONE: if (!load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start     = (state == IDLE) && load;
  assign mem_we    = handshake;
  assign mem_addr  = count[ADDR_W-1:0];
  assign mem_wdata = {in_x, in_y};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      aborted   <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= (state_nxt == DONE);
      if (start) begin
        count   <= '0;
        aborted <= 1'b0;
      end else if (handshake) begin
        count <= count + 1'b1;
      end
      if ((state == FILL) && !load)
        aborted <= 1'b1;
    end
  end

`ifdef PIP_LOADER_CHECKSUM_EN
  logic [COORD_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst)
      sum_q <= '0;
    else if (start)
      sum_q <= '0;
    else if (handshake)
      sum_q <= sum_q + in_x + in_y;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_pip_point_loader.sv
// tb/tb_pip_point_loader.sv - scoreboard bench for pip_point_loader (directed plus randomized stimulus)
module tb_pip_point_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_done;
  logic [4:0]  count;
  logic        aborted;
  logic [15:0] checksum;

  pip_point_loader #(.NUM_POINTS(16), .COORD_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .load_done(load_done), .count(count),
    .aborted(aborted), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } wexp_t;

  typedef struct {
    logic        done;
    logic [4:0]  cnt;
    logic        ab;
    logic [15:0] sum;
  } sexp_t;

  wexp_t wq[$];
  sexp_t sq[$];

  int n_cmp = 0;
  int n_fail = 0;
  bit running = 1'b1;

`ifdef PIP_LOADER_CHECKSUM_EN
  localparam logic [15:0] EXP_WRAP = 16'h0003;
`else
  localparam logic [15:0] EXP_WRAP = 16'h0000;
`endif

  // Reference model: load phase, points accepted so far, abort flag, running sum.
  typedef enum {P_IDLE, P_FILL, P_DONE} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_n = 0;
  bit          m_ab = 1'b0;
  logic [15:0] m_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = P_IDLE; m_n = 0; m_ab = 1'b0; m_sum = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (load) begin
          m_phase = P_FILL; m_n = 0; m_ab = 1'b0; m_sum = '0;
        end
        P_FILL: begin
          if (!load) begin
            m_phase = P_IDLE; m_ab = 1'b1;
          end else if (in_valid) begin
            m_n = m_n + 1;
`ifdef PIP_LOADER_CHECKSUM_EN
            m_sum = m_sum + in_x + in_y;
`endif
            if (m_n == 16) m_phase = P_DONE;
          end
        end
        P_DONE: if (!load) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // One clock: advance the model through the edge, then apply new inputs.
  task automatic cyc(input logic r, input logic l, input logic v,
                     input logic [15:0] x, input logic [15:0] y);
    sexp_t s;
    wexp_t w;
    @(posedge clk);
    model_step();
    s.done = (m_phase == P_DONE);
    s.cnt  = 5'(m_n);
    s.ab   = m_ab;
    s.sum  = m_sum;
    sq.push_back(s);
    #2;
    rst = r; load = l; in_valid = v; in_x = x; in_y = y;
    w.rdy  = (m_phase == P_FILL) && l;
    w.we   = w.rdy && v;
    w.addr = 4'(m_n);
    w.data = {x, y};
    wq.push_back(w);
  endtask

  task automatic fill_until(input int target, input int stall_mod);
    int guard = 0;
    int k = 0;
    while (!(m_phase == P_DONE || (m_phase == P_FILL && m_n == target)) && guard < 200) begin
      cyc(1'b0, 1'b1, (k % stall_mod) == 0, 16'(m_n), 16'(2 * m_n));
      k++;
      guard++;
    end
    if (guard >= 200) chk("fill_timeout", 64'(guard), 64'd0);
  endtask

  initial begin
    wexp_t w;
    sexp_t s;
    forever begin
      @(negedge clk);
      if (running) begin
        if (wq.size() == 0 || sq.size() == 0) begin
          chk("queue_underflow", 64'(wq.size() + sq.size()), 64'd2);
        end else begin
          w = wq.pop_front();
          s = sq.pop_front();
          chk("load_done", 64'(load_done), 64'(s.done));
          chk("count", 64'(count), 64'(s.cnt));
          chk("aborted", 64'(aborted), 64'(s.ab));
          chk("checksum", 64'(checksum), 64'(s.sum));
          chk("in_ready", 64'(in_ready), 64'(w.rdy));
          chk("mem_we", 64'(mem_we), 64'(w.we));
          if (w.we) begin
            chk("mem_addr", 64'(mem_addr), 64'(w.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(w.data));
          end
        end
      end
    end
  end

  initial begin
    logic r, l, v;
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 16'h5678);

    // basic fill, x=i y=2i, back-to-back
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    fill_until(16, 1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 16'hBBBB, 16'hCCCC);

    // stalled source 1,0,0,...
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    fill_until(16, 3);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // abort after 5 writes with in_valid still high
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    fill_until(5, 1);
    cyc(1'b0, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    fill_until(2, 1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // reset mid-fill after 7 writes
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    fill_until(7, 1);
    cyc(1'b1, 1'b1, 1'b1, 16'h7777, 16'h7777);
    cyc(1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // checksum wrap-around
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 1'b1, 16'h8000, 16'h8000);
    cyc(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("checksum_wrap", 64'(checksum), 64'(EXP_WRAP));

    // randomized traffic with sticky load and rare resets
    l = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) l = ~l;
      v = ($urandom_range(0, 2) != 0);
      cyc(r, l, v, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end

    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    running = 1'b0;
    chk("queues_drained", 64'(wq.size() + sq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pip_point_loader.md
Name: pip_point_loader

Overview:
- Producer side of the controller's load handshake. The controller holds its LOAD control bit high and waits for load_done; this block is what answers it.
- While LOAD is high, it accepts a stream of (x,y) points over a valid/ready interface and writes them into sequential addresses of the point memory.
- It asserts load_done once NUM_POINTS entries are committed, so the controller can leave its load state and begin checking.

Parameters:
- NUM_POINTS, 16, number of points per load; legal range 1..2**ADDR_W.
- COORD_W, 16, width of each coordinate.
- ADDR_W, 4, point-memory address width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  LOAD bit of the controller control word; level request.
- in_valid  in  1  source has a point available.
- in_ready  out  1  loader accepts a point this cycle.
- in_x  in  COORD_W  point x coordinate.
- in_y  in  COORD_W  point y coordinate.
- mem_we  out  1  point-memory write enable.
- mem_addr  out  ADDR_W  point-memory write address.
- mem_wdata  out  2*COORD_W  write data, {in_x, in_y}.
- load_done  out  1  all NUM_POINTS entries written; level.
- count  out  ADDR_W+1  number of points written in the current load.
- aborted  out  1  sticky flag: last load was cut short.
- checksum  out  COORD_W  running point checksum; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-load):
  - state=IDLE, count=0, aborted=0, checksum=0, load_done=0.
  - Combinational outputs follow: in_ready=0, mem_we=0.
- FSM states: IDLE, FILL, DONE. All state is registered; transitions occur on clk.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - load=1 -> FILL; count cleared to 0 and aborted cleared to 0 on the same edge.
- FILL:
  - in_ready = load (combinational).
  - Handshake = in_valid & in_ready.
  - mem_we = handshake; mem_addr = count[ADDR_W-1:0]; mem_wdata = {in_x, in_y}. All three are combinational, so the memory commits on the same edge as the handshake; write latency is 0.
  - On each handshake, count increments by 1 at the edge.
  - Handshake when count == NUM_POINTS-1 -> DONE. count ends at NUM_POINTS.
  - load=0 while in FILL -> IDLE with aborted=1.
    - No write occurs that cycle, because in_ready=0. Abort wins over a simultaneous in_valid.
    - count holds its partial value; written memory contents are left as-is.
- DONE:
  - load_done=1 (registered; first high the cycle after the final write); in_ready=0; mem_we=0.
  - load=0 -> IDLE; load_done drops on that edge. count holds until the next load.
  - load held high -> stay in DONE. There is no auto-restart.
- Output widths and encoding:
  - count is ADDR_W+1 bits so it can represent NUM_POINTS = 2**ADDR_W.
  - mem_addr never wraps within a load.
- in_x and in_y are sampled only on a handshake cycle; they are don't-care otherwise.
- NUM_POINTS=1: a single handshake goes FILL -> DONE.
- Back-to-back loads: the controller returning to load=1 while in IDLE starts a fresh fill from address 0.

Optional Feature:
- Macro: PIP_LOADER_CHECKSUM_EN.
- Defined:
  - checksum is cleared on entry to FILL.
  - On each handshake, checksum <= checksum + in_x + in_y, truncated mod 2**COORD_W.
  - The value holds in DONE and IDLE until the next load starts.
- Undefined: checksum is tied to 0 and no adder logic is generated.

Test Plan:
- Basic fill:
  - Stimulus: rst for 2 cycles, then load=1 and 16 consecutive points with in_valid=1, x=i, y=2i.
  - Response: mem_we high for 16 cycles, mem_addr 0..15, mem_wdata={i,2i}; load_done rises the cycle after the 16th write; count=16.
- Source stalls:
  - Stimulus: in_valid toggled 1,0,0,1,...
  - Response: mem_we only on in_valid cycles, addresses contiguous with no gaps; load_done only after the 16th accepted point.
- Abort mid-load:
  - Stimulus: load drops after 5 writes, with in_valid=1 in that same cycle.
  - Response: no 6th write; state IDLE; aborted=1; count=5; load_done=0. A following load=1 restarts at mem_addr 0 and clears aborted.
- Handshake release and idle behaviour:
  - Stimulus: hold load=1 for 3 cycles in DONE, then drop it.
  - Response: load_done stays 1 for those cycles and drops on the edge after load=0. in_valid=1 while in IDLE/DONE gives in_ready=0 and mem_we=0.
- Reset mid-fill:
  - Stimulus: assert rst after 7 writes.
  - Response: next cycle state IDLE, count=0, load_done=0, in_ready=0.
- Checksum (PIP_LOADER_CHECKSUM_EN defined):
  - Stimulus: points (0x8000,0x8000) then (1,2) with COORD_W=16.
  - Response: checksum = 0x0003 (wrap-around verified).
  - With the macro undefined: checksum stays 0.
